// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C slave responder.
package i2c_pkg;

   localparam int unsigned I2C_BYTE_BITS = 8;
   localparam int unsigned I2C_BIT_CNT_W = 3;
   localparam int unsigned I2C_TX_BITS   = 2 * I2C_BYTE_BITS;

   localparam logic I2C_ACK  = 1'b0;
   localparam logic I2C_NACK = 1'b1;

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_ADDR      = 3'd1;
   localparam logic [2:0] S_ADDR_ACK  = 3'd2;
   localparam logic [2:0] S_RX_BYTE   = 3'd3;
   localparam logic [2:0] S_RX_ACK    = 3'd4;
   localparam logic [2:0] S_TX_BYTE   = 3'd5;
   localparam logic [2:0] S_TX_ACK    = 3'd6;
   localparam logic [2:0] S_WAIT_STOP = 3'd7;

   typedef enum logic [2:0] {
      ST_IDLE      = S_IDLE,
      ST_ADDR      = S_ADDR,
      ST_ADDR_ACK  = S_ADDR_ACK,
      ST_RX_BYTE   = S_RX_BYTE,
      ST_RX_ACK    = S_RX_ACK,
      ST_TX_BYTE   = S_TX_BYTE,
      ST_TX_ACK    = S_TX_ACK,
      ST_WAIT_STOP = S_WAIT_STOP
   } i2c_slave_state_t;

endpackage

// File: rtl/i2c_slave_responder_line_sync.sv
// Synchronizer and edge detector for one I2C line (SCL or SDA).
// Define I2C_SLAVE_GLITCH_FILTER_EN to insert a 3-sample majority filter after the synchronizer.
module i2c_line_sync (
   input  logic clock,
   input  logic Reset,
   input  logic i_line,
   output logic o_level,
   output logic o_rise,
   output logic o_fall
);

   logic [1:0] r_sync;
   logic       w_clean;
   logic       r_level;
   logic       r_rise;
   logic       r_fall;

   always_ff @(posedge clock) begin
      if (Reset) begin
         r_sync <= 2'b11;
      end else begin
         r_sync <= {r_sync[0], i_line};
      end
   end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
   logic [1:0] r_hist;
   logic       r_filt;
   logic       w_maj;

   // 2-of-3 vote over the current and two previous synchronized samples
   assign w_maj = (r_sync[1] & r_hist[0]) | (r_sync[1] & r_hist[1]) | (r_hist[0] & r_hist[1]);

   always_ff @(posedge clock) begin
      if (Reset) begin
         r_hist <= 2'b11;
         r_filt <= 1'b1;
      end else begin
         r_hist <= {r_hist[0], r_sync[1]};
         r_filt <= w_maj;
      end
   end

   assign w_clean = r_filt;
`else
   assign w_clean = r_sync[1];
`endif

   // Level and edge pulses are registered together so they stay aligned
   always_ff @(posedge clock) begin
      if (Reset) begin
         r_level <= 1'b1;
         r_rise  <= 1'b0;
         r_fall  <= 1'b0;
      end else begin
         r_level <= w_clean;
         r_rise  <= w_clean & ~r_level;
         r_fall  <= ~w_clean & r_level;
      end
   end

   assign o_level = r_level;
   assign o_rise  = r_rise;
   assign o_fall  = r_fall;

endmodule

// File: rtl/i2c_slave_responder.sv
// I2C target: START/STOP detection, 7-bit address match, byte capture on write, 16-bit register read.
// Optional input glitch filter via I2C_SLAVE_GLITCH_FILTER_EN (see i2c_line_sync).
module i2c_slave_responder
   import i2c_pkg::*;
#(
   parameter logic [6:0] SlaveAddress = 7'b1001000
) (
   input  logic                     clock,
   input  logic                     Reset,
   input  logic                     SCL,
   inout  wire                      SDA,
   input  logic [I2C_TX_BITS-1:0]   TxData,
   output logic [I2C_BYTE_BITS-1:0] RxData,
   output logic                     RxValid,
   output logic                     AddressMatch,
   output logic                     Busy
);

   localparam int unsigned ByteW = I2C_BYTE_BITS;
   localparam int unsigned TxW   = I2C_TX_BITS;
   localparam int unsigned CntW  = I2C_BIT_CNT_W;

   logic w_scl_level, w_scl_rise, w_scl_fall;
   logic w_sda_level, w_sda_rise, w_sda_fall;
   logic w_start, w_stop, w_last_bit;
   logic [ByteW-1:0] w_shift_in, w_tx_next_byte;

   i2c_slave_state_t r_state, w_state_nxt;
   logic [CntW-1:0]  r_bit_cnt, w_bit_cnt_nxt;
   logic [ByteW-1:0] r_shift, w_shift_nxt;
   logic [TxW-1:0]   r_tx_data, w_tx_data_nxt;
   logic [ByteW-1:0] r_rx_data, w_rx_data_nxt;
   logic r_byte_idx, w_byte_idx_nxt;
   logic r_rw, w_rw_nxt;
   logic r_phase, w_phase_nxt;
   logic r_sda_oe, w_sda_oe_nxt;
   logic r_rx_valid, w_rx_valid_nxt;
   logic r_addr_match, w_addr_match_nxt;
   logic r_busy, w_busy_nxt;

   i2c_line_sync u_scl_sync (
      .clock   (clock),
      .Reset   (Reset),
      .i_line  (SCL),
      .o_level (w_scl_level),
      .o_rise  (w_scl_rise),
      .o_fall  (w_scl_fall)
   );

   i2c_line_sync u_sda_sync (
      .clock   (clock),
      .Reset   (Reset),
      .i_line  (SDA),
      .o_level (w_sda_level),
      .o_rise  (w_sda_rise),
      .o_fall  (w_sda_fall)
   );

   assign w_start        = w_sda_fall & w_scl_level;
   assign w_stop         = w_sda_rise & w_scl_level;
   assign w_last_bit     = (r_bit_cnt == CntW'(ByteW - 1));
   assign w_shift_in     = {r_shift[ByteW-2:0], w_sda_level};
   // Byte that follows the current one once the index toggles
   assign w_tx_next_byte = r_byte_idx ? r_tx_data[TxW-1:ByteW] : r_tx_data[ByteW-1:0];

   always_comb begin
      w_state_nxt      = r_state;
      w_bit_cnt_nxt    = r_bit_cnt;
      w_shift_nxt      = r_shift;
      w_tx_data_nxt    = r_tx_data;
      w_rx_data_nxt    = r_rx_data;
      w_byte_idx_nxt   = r_byte_idx;
      w_rw_nxt         = r_rw;
      w_phase_nxt      = r_phase;
      w_sda_oe_nxt     = r_sda_oe;
      w_rx_valid_nxt   = 1'b0;
      w_addr_match_nxt = r_addr_match;
      w_busy_nxt       = r_busy;

      if (w_stop) begin
         w_state_nxt      = ST_IDLE;
         w_bit_cnt_nxt    = '0;
         w_phase_nxt      = 1'b0;
         w_sda_oe_nxt     = 1'b0;
         w_addr_match_nxt = 1'b0;
         w_busy_nxt       = 1'b0;
      end else if (w_start) begin
         w_state_nxt      = ST_ADDR;
         w_bit_cnt_nxt    = '0;
         w_phase_nxt      = 1'b0;
         w_sda_oe_nxt     = 1'b0;
         w_addr_match_nxt = 1'b0;
         w_busy_nxt       = 1'b1;
      end else begin
         case (r_state)
            ST_ADDR: begin
               if (w_scl_rise) begin
                  w_shift_nxt   = w_shift_in;
                  w_bit_cnt_nxt = r_bit_cnt + CntW'(1);
                  if (w_last_bit) begin
                     if (w_shift_in[ByteW-1:1] == SlaveAddress) begin
                        w_state_nxt      = ST_ADDR_ACK;
                        w_rw_nxt         = w_shift_in[0];
                        w_addr_match_nxt = 1'b1;
                     end else begin
                        w_state_nxt = ST_WAIT_STOP;
                     end
                  end
               end
            end
            // First SCL fall starts the ACK low, second fall ends it
            ST_ADDR_ACK, ST_RX_ACK: begin
               if (w_scl_fall) begin
                  if (!r_phase) begin
                     w_phase_nxt  = 1'b1;
                     w_sda_oe_nxt = 1'b1;
                  end else begin
                     w_phase_nxt  = 1'b0;
                     w_sda_oe_nxt = 1'b0;
                     if ((r_state == ST_ADDR_ACK) && r_rw) begin
                        w_state_nxt    = ST_TX_BYTE;
                        w_tx_data_nxt  = TxData;
                        w_byte_idx_nxt = 1'b0;
                        w_shift_nxt    = TxData[TxW-1:ByteW];
                        w_sda_oe_nxt   = ~TxData[TxW-1];
                     end else begin
                        w_state_nxt = ST_RX_BYTE;
                     end
                  end
               end
            end
            ST_RX_BYTE: begin
               if (w_scl_rise) begin
                  w_shift_nxt   = w_shift_in;
                  w_bit_cnt_nxt = r_bit_cnt + CntW'(1);
                  if (w_last_bit) begin
                     w_rx_data_nxt  = w_shift_in;
                     w_rx_valid_nxt = 1'b1;
                     w_state_nxt    = ST_RX_ACK;
                  end
               end
            end
            ST_TX_BYTE: begin
               if (w_scl_fall) begin
                  w_bit_cnt_nxt = r_bit_cnt + CntW'(1);
                  if (w_last_bit) begin
                     w_sda_oe_nxt = 1'b0;
                     w_state_nxt  = ST_TX_ACK;
                  end else begin
                     w_shift_nxt  = {r_shift[ByteW-2:0], 1'b0};
                     w_sda_oe_nxt = ~r_shift[ByteW-2];
                  end
               end
            end
            // Master's bit is sampled on rise; the next byte starts on the following fall
            ST_TX_ACK: begin
               if (w_scl_rise) begin
                  if (w_sda_level == I2C_NACK) begin
                     w_state_nxt = ST_WAIT_STOP;
                  end else begin
                     w_phase_nxt = 1'b1;
                  end
               end else if (w_scl_fall && r_phase) begin
                  w_phase_nxt    = 1'b0;
                  w_byte_idx_nxt = ~r_byte_idx;
                  w_shift_nxt    = w_tx_next_byte;
                  w_sda_oe_nxt   = ~w_tx_next_byte[ByteW-1];
                  w_state_nxt    = ST_TX_BYTE;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (Reset) begin
         r_state      <= ST_IDLE;
         r_bit_cnt    <= '0;
         r_shift      <= '0;
         r_tx_data    <= '0;
         r_rx_data    <= '0;
         r_byte_idx   <= 1'b0;
         r_rw         <= 1'b0;
         r_phase      <= 1'b0;
         r_sda_oe     <= 1'b0;
         r_rx_valid   <= 1'b0;
         r_addr_match <= 1'b0;
         r_busy       <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_bit_cnt    <= w_bit_cnt_nxt;
         r_shift      <= w_shift_nxt;
         r_tx_data    <= w_tx_data_nxt;
         r_rx_data    <= w_rx_data_nxt;
         r_byte_idx   <= w_byte_idx_nxt;
         r_rw         <= w_rw_nxt;
         r_phase      <= w_phase_nxt;
         r_sda_oe     <= w_sda_oe_nxt;
         r_rx_valid   <= w_rx_valid_nxt;
         r_addr_match <= w_addr_match_nxt;
         r_busy       <= w_busy_nxt;
      end
   end

   // Open drain: only ever pull low or release
   assign SDA          = r_sda_oe ? 1'b0 : 1'bz;
   assign RxData       = r_rx_data;
   assign RxValid      = r_rx_valid;
   assign AddressMatch = r_addr_match;
   assign Busy         = r_busy;

endmodule

// File: tb/tb_i2c_slave_responder.sv
// Bench for i2c_slave_responder: bus-level master, scoreboard queues and a transaction-level model.
module tb_i2c_slave_responder;

   localparam logic [6:0] SLAVE = 7'b1001000;
   localparam int Q = 10;

   logic        clk = 1'b0;
   logic        rst;
   logic        scl;
   logic        m_low;
   logic [15:0] tx_data;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        addr_match;
   logic        busy;
   wire         sda;

   assign sda = m_low ? 1'b0 : 1'bz;
   pullup (sda);

   i2c_slave_responder #(.SlaveAddress(SLAVE)) dut (
      .clock        (clk),
      .Reset        (rst),
      .SCL          (scl),
      .SDA          (sda),
      .TxData       (tx_data),
      .RxData       (rx_data),
      .RxValid      (rx_valid),
      .AddressMatch (addr_match),
      .Busy         (busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       is_byte;
      logic [7:0] val;
   } bus_item_t;

   bus_item_t  exp_bus_q[$];
   bus_item_t  obs_bus_q[$];
   logic [7:0] exp_rx_q[$];
   int n_pass  = 0;
   int n_total = 0;

   function automatic void chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
   endfunction

   function automatic void push_exp(input logic is_byte, input logic [7:0] val);
      bus_item_t it;
      it.is_byte = is_byte;
      it.val     = val;
      exp_bus_q.push_back(it);
   endfunction

   function automatic void push_obs(input logic is_byte, input logic [7:0] val);
      bus_item_t it;
      it.is_byte = is_byte;
      it.val     = val;
      obs_bus_q.push_back(it);
   endfunction

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic clock_bit(input logic b, output logic r);
      m_low = ~b;
      wait_clk(Q);
      scl = 1'b1;
      wait_clk(Q);
      r = sda;
      wait_clk(Q);
      scl = 1'b0;
      wait_clk(Q);
   endtask

   task automatic send_byte(input logic [7:0] b);
      logic r;
      for (int i = 7; i >= 0; i--) clock_bit(b[i], r);
   endtask

   task automatic read_byte(output logic [7:0] v);
      logic r;
      v = 8'h00;
      for (int i = 0; i < 8; i++) begin
         clock_bit(1'b1, r);
         v = {v[6:0], r};
      end
   endtask

   task automatic bus_start();
      m_low = 1'b0;
      wait_clk(Q);
      scl = 1'b1;
      wait_clk(Q);
      m_low = 1'b1;
      wait_clk(Q);
      scl = 1'b0;
      wait_clk(Q);
   endtask

   task automatic bus_stop();
      m_low = 1'b1;
      wait_clk(Q);
      scl = 1'b1;
      wait_clk(Q);
      m_low = 1'b0;
      wait_clk(Q);
   endtask

   // Model: matched address ACKs everything written; reads return TxData high/low bytes alternately
   task automatic txn_body(input logic [6:0] a, input logic rw, input int n,
                           input logic [23:0] data, input logic [15:0] tx);
      logic       matched;
      logic       r;
      logic [7:0] v;
      logic [7:0] e;
      matched = (a == SLAVE);
      tx_data = tx;
      bus_start();
      chk("busy_after_start", 16'(busy), 16'd1);
      push_exp(1'b0, {7'd0, ~matched});
      send_byte({a, rw});
      clock_bit(1'b1, r);
      push_obs(1'b0, {7'd0, r});
      chk("addr_match_after_ack", 16'(addr_match), 16'(matched));
      if (rw) tx_data = 16'($urandom);
      for (int k = 0; k < n; k++) begin
         if (!rw) begin
            v = data[8*k +: 8];
            if (matched) exp_rx_q.push_back(v);
            push_exp(1'b0, {7'd0, ~matched});
            send_byte(v);
            clock_bit(1'b1, r);
            push_obs(1'b0, {7'd0, r});
         end else begin
            e = !matched ? 8'hFF : ((k % 2) == 0) ? tx[15:8] : tx[7:0];
            push_exp(1'b1, e);
            read_byte(v);
            push_obs(1'b1, v);
            clock_bit(logic'(k == n - 1), r);
         end
      end
      if (rw && n > 0) chk("sda_released_after_nack", 16'(sda), 16'd1);
   endtask

   task automatic end_txn();
      chk("busy_before_stop", 16'(busy), 16'd1);
      bus_stop();
      chk("busy_after_stop", 16'(busy), 16'd0);
      chk("match_after_stop", 16'(addr_match), 16'd0);
   endtask

   // Bus monitor: compares every ACK bit / read byte the master observed
   initial begin
      bus_item_t o;
      bus_item_t e;
      forever begin
         @(negedge clk);
         while (obs_bus_q.size() > 0) begin
            o = obs_bus_q.pop_front();
            if (exp_bus_q.size() == 0) begin
               chk("bus_unexpected", 16'(exp_bus_q.size()), 16'd1);
            end else begin
               e = exp_bus_q.pop_front();
               chk(e.is_byte ? "read_byte" : "ack_bit", {7'd0, o.is_byte, o.val}, {7'd0, e.is_byte, e.val});
            end
         end
      end
   end

   // RxValid monitor: each pulse must match the next expected written byte and last one clock
   initial begin
      logic [7:0] e;
      forever begin
         @(negedge clk);
         if (rx_valid === 1'b1) begin
            chk("rx_pending", 16'(exp_rx_q.size() > 0), 16'd1);
            if (exp_rx_q.size() > 0) begin
               e = exp_rx_q.pop_front();
               chk("rx_data", 16'(rx_data), 16'(e));
            end
            @(negedge clk);
            chk("rxvalid_width", 16'(rx_valid), 16'd0);
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [6:0]  a;
      logic        r;
      logic [2:0]  part;
      rst     = 1'b1;
      scl     = 1'b1;
      m_low   = 1'b0;
      tx_data = 16'h0000;
      wait_clk(3);
      rst = 1'b0;
      wait_clk(2);
      chk("reset_busy", 16'(busy), 16'd0);
      chk("reset_match", 16'(addr_match), 16'd0);
      chk("reset_rxvalid", 16'(rx_valid), 16'd0);
      chk("reset_rxdata", 16'(rx_data), 16'h0000);
      chk("reset_sda", 16'(sda), 16'd1);

      // write 0x90, 0x01
      txn_body(SLAVE, 1'b0, 1, 24'h000001, 16'h0000);
      end_txn();
      chk("rxdata_after_write", 16'(rx_data), 16'h0001);

      // read two bytes, then three to exercise the wrap
      txn_body(SLAVE, 1'b1, 2, 24'h0, 16'h1A40);
      end_txn();
      txn_body(SLAVE, 1'b1, 3, 24'h0, 16'h1A40);
      end_txn();

      // 0x92: no match
      txn_body(7'h49, 1'b0, 0, 24'h0, 16'h0000);
      end_txn();

      // write 0x00, repeated START, read
      txn_body(SLAVE, 1'b0, 1, 24'h000000, 16'h0000);
      txn_body(SLAVE, 1'b1, 1, 24'h0, 16'h1A40);
      end_txn();
      chk("rxdata_retained", 16'(rx_data), 16'h0000);

      // reset while the slave is driving a zero data bit
      tx_data = 16'h0F55;
      bus_start();
      push_exp(1'b0, 8'h00);
      send_byte({SLAVE, 1'b1});
      clock_bit(1'b1, r);
      push_obs(1'b0, {7'd0, r});
      part = 3'b111;
      for (int i = 0; i < 3; i++) begin
         clock_bit(1'b1, r);
         part = {part[1:0], r};
      end
      chk("tx_first_bits", 16'(part), 16'h0000);
      chk("tx_bit3_driven", 16'(sda), 16'd0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("sda_released_after_reset", 16'(sda), 16'd1);
      chk("busy_after_reset", 16'(busy), 16'd0);
      chk("match_after_reset", 16'(addr_match), 16'd0);
      wait_clk(Q);
      txn_body(SLAVE, 1'b1, 2, 24'h0, 16'(16'hC3A5));
      end_txn();

      for (int t = 0; t < 12; t++) begin
         a = ($urandom_range(0, 3) == 0) ? 7'($urandom) : SLAVE;
         txn_body(a, 1'($urandom), $urandom_range(1, 3), 24'($urandom), 16'($urandom));
         end_txn();
      end

      wait_clk(5);
      chk("rx_queue_drained", 16'(exp_rx_q.size()), 16'd0);
      chk("bus_queue_drained", 16'(exp_bus_q.size()), 16'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/i2c_slave_responder.md
# i2c_slave_responder

I2C slave (responder) for the TMP101 lab bench: the target-side counterpart to the I2C master built from the controller, data unit and baud-rate generator. It oversamples SCL and SDA on the system clock, detects START and STOP, matches a 7-bit address and acknowledges it. On writes it captures bytes; on reads it returns a 16-bit register MSB-first. It sits on the same open-drain SDA/SCL pair as the master, standing in for the sensor in simulation and on the board.

## Interface
- `SlaveAddress`, default `7'b1001000`: 7-bit address this slave answers to (TMP101, ADD0=GND).
- `clock`, input, 1: system clock (60 MHz); all logic on its rising edge.
- `Reset`, input, 1: synchronous, active-high reset.
- `SCL`, input, 1: I2C clock from the master. This block never drives SCL.
- `SDA`, inout, 1: open-drain data line. Driven `1'b0` or `1'bz` only; never driven `1`.
- `TxData`, input, 16: read register, latched at the address ACK.
- `RxData`, output, 8: last byte written by the master.
- `RxValid`, output, 1: one-cycle pulse when `RxData` updates.
- `AddressMatch`, output, 1: high from address ACK until STOP or repeated START.
- `Busy`, output, 1: high from START until STOP.

## Operation
- **Synchronization.** SCL and SDA pass through 2-flop synchronizers. Edges are detected on the synchronized copies.
  - START: SDA falls while SCL is high. STOP: SDA rises while SCL is high.
- **Data timing.** Data is sampled on an SCL rising edge. The slave changes SDA only on an SCL falling edge.
- **States:** IDLE, ADDR, ADDR_ACK, RX_BYTE, RX_ACK, TX_BYTE, TX_ACK, WAIT_STOP.
- **IDLE → ADDR** on START. ADDR shifts in 8 bits, MSB first.
- **Address compare** after the 8th bit, on `{addr[6:0], rw}`:
  - Match → ADDR_ACK. Pull SDA low from the next SCL fall until the following SCL fall.
  - Mismatch → WAIT_STOP. SDA stays released.
- **After ADDR_ACK:**
  - rw=0 → RX_BYTE.
  - rw=1 → TX_BYTE. `TxData` is latched at entry; byte index starts at 0.
- **RX_BYTE.** Shift in 8 bits, then update `RxData` and pulse `RxValid`. Go to RX_ACK, which drives an ACK exactly like ADDR_ACK, then return to RX_BYTE. There is no byte limit.
- **TX_BYTE.** Drive byte 0 = `TxData[15:8]`, then byte 1 = `TxData[7:0]`, MSB first.
  - A 0 bit is driven low; a 1 bit is released.
  - After the 8th bit, release SDA and go to TX_ACK.
- **TX_ACK.** Sample the master's bit on SCL rise.
  - ACK (0) → TX_BYTE; the byte index toggles, so a read wraps 0,1,0,1…
  - NACK (1) → WAIT_STOP.
- **WAIT_STOP.** SDA released; wait for STOP or START.
- **Global overrides, any state:**
  - STOP → IDLE.
  - START (including a repeated START) → ADDR, bit counter cleared, `AddressMatch` cleared.
  - These override all other transitions in the same cycle.
- **Reset** mid-transfer → IDLE immediately, with SDA released.

## Timing
- **Reset values:** state IDLE, SDA `z`, `RxData=8'h00`, `RxValid=0`, `AddressMatch=0`, `Busy=0`, bit counter 0, synchronizers loaded with 1.
- **Edge-detect latency:** 3 clocks from a pin change to the detected edge (2 sync + 1 compare).
- **SDA drive change:** 1 clock after the detected SCL fall, i.e. 4 clocks after the pin edge. This is well within tHD;DAT at 30 kHz/60 MHz.
- **`RxValid`:** asserted the clock after the 8th data bit's detected SCL rise. Width exactly 1 clock.
- **`AddressMatch`:** set on the same clock ADDR_ACK is entered.
- **`Busy`:** set the clock START is detected; cleared the clock STOP is detected.
- **Bit counter:** 3 bits. It wraps 7→0 at the byte boundary and is cleared on START.

## Configuration
- **`I2C_SLAVE_GLITCH_FILTER_EN` defined:** a 3-sample majority filter follows each synchronizer.
  - Edge latency becomes 5 clocks; SDA drive becomes 6 clocks after the pin edge.
  - Pulses shorter than 2 clocks are rejected.
- **Undefined:** no filter; latencies are as given under Timing.

## Structure
- **Package `i2c_pkg`:** state enum `i2c_slave_state_t`, `I2C_ACK=1'b0`, `I2C_NACK=1'b1`, byte-width constant `I2C_BYTE_BITS=8`.
- **Sub-module `i2c_line_sync`:** one instance per line (SCL, SDA). It contains the synchronizer, the optional filter, and rise/fall outputs. The FSM and shifters stay in the top module.

## Test plan
- **Write with address match:** START, `8'h90`, `8'h01`, STOP.
  - Slave ACKs both bytes.
  - `RxData=8'h01` with a single `RxValid` pulse.
  - `AddressMatch` drops at STOP.
- **Read with address match:** `TxData=16'h1A40`; START, `8'h91`.
  - Master receives `8'h1A`, sends ACK, receives `8'h40`, sends NACK, then STOP.
  - SDA is released after the NACK.
- **Read wrap-around:** the same read with ACK after byte 1 → the third byte is `8'h1A`.
- **Address mismatch:** START, `8'h92`.
  - SDA stays `z` on the 9th clock; `AddressMatch=0`; `RxValid` never pulses; `Busy=1` until STOP.
- **Repeated START:** START, `8'h90`, `8'h00`, then repeated START, `8'h91`.
  - Slave returns `TxData[15:8]`.
  - `RxData=8'h00` from the first phase is retained.
- **Reset mid-transfer:** assert `Reset` for 1 clock during TX bit 3.
  - SDA is `z` on the next clock; state IDLE; `Busy=0`.
  - The next START is handled normally.
